// File: rtl/uart_boot_loader_pkg.sv
// Shared types and constants for the UART boot loader.
// Optional feature macro: BOOT_CHECKSUM_EN (adds a trailing CSUM byte check).
package boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CSUM,
        ST_ACK,
        ST_NAK,
        ST_RUN
    } boot_state_t;

    localparam logic [7:0] BOOT_SYNC = 8'hA5;
    localparam logic [7:0] BOOT_ACK  = 8'h06;
    localparam logic [7:0] BOOT_NAK  = 8'h15;

endpackage

// File: rtl/uart_boot_loader_if.sv
// Byte stream, response and instruction-memory write signals of the boot loader.
// master = UART/memory side environment, slave = the loader itself.
interface uart_boot_loader_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        im_wr_en;
    logic [31:0] im_wr_addr;
    logic [31:0] im_wr_data;
    logic [7:0]  ack_data;
    logic        ack_valid;
    logic        ack_ready;
    logic        core_run;
    logic        boot_error;

    modport master (
        output rx_data, rx_valid, ack_ready,
        input  rx_ready, im_wr_en, im_wr_addr, im_wr_data,
        input  ack_data, ack_valid, core_run, boot_error
    );

    modport slave (
        input  rx_data, rx_valid, ack_ready,
        output rx_ready, im_wr_en, im_wr_addr, im_wr_data,
        output ack_data, ack_valid, core_run, boot_error
    );

endinterface

// File: rtl/uart_boot_loader_word_packer.sv
// Packs a byte stream into little-endian 32-bit words; first byte lands in [7:0].
// word_valid_o pulses for one cycle after the 4th byte of each word.
module boot_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic [31:0] word_o,
    output logic        word_valid_o,
    output logic [1:0]  lane_o
);

    logic [23:0] shift_q;
    logic [31:0] word_q;
    logic        word_valid_q;
    logic [1:0]  lane_q;

    // Shift bytes in from the top so the oldest byte ends up in the low lane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q      <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            lane_q       <= '0;
        end else begin
            word_valid_q <= 1'b0;
            if (clear_i) begin
                lane_q <= '0;
            end else if (byte_valid_i) begin
                lane_q  <= lane_q + 2'd1;
                shift_q <= {byte_i, shift_q[23:8]};
                if (lane_q == 2'd3) begin
                    word_q       <= {byte_i, shift_q};
                    word_valid_q <= 1'b1;
                end
            end
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = word_valid_q;
    assign lane_o       = lane_q;

endmodule

// File: rtl/uart_boot_loader.sv
// Boot loader: receives SYNC/LEN/payload[/CSUM] frames over UART, writes words
// into instruction memory from BASE_ADDR, then releases the core with core_run.
// Optional feature macro: BOOT_CHECKSUM_EN (8-bit modular sum of the payload).
module uart_boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned IM_ADDR_W      = 10,
    parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input logic               clk,
    input logic               rst_n,
    uart_boot_loader_if.slave bus
);

    localparam int unsigned TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [16:0] CAPACITY = 17'd1 << IM_ADDR_W;

    boot_state_t          state_q;
    logic                 rx_ready_q;
    logic                 ack_valid_q;
    logic [7:0]           ack_data_q;
    logic                 core_run_q;
    logic                 boot_error_q;
    logic [7:0]           len_lo_q;
    logic [15:0]          len_q;
    logic [IM_ADDR_W:0]   idx_q;
    logic [IM_ADDR_W:0]   idx_d;
    logic [31:0]          addr_q;
    logic [TO_W-1:0]      to_cnt_q;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]           sum_q;
`endif

    logic        rx_fire, sync_fire, data_fire, word_last, timed, timeout_hit;
    logic        len_bad, enter_ack, enter_nak, hs_done;
    logic [15:0] len_n;
    logic [31:0] word;
    logic        word_valid;
    logic [1:0]  lane;

    assign rx_fire     = bus.rx_valid & rx_ready_q;
    assign sync_fire   = rx_fire && (state_q == ST_IDLE) && (bus.rx_data == BOOT_SYNC);
    assign data_fire   = rx_fire && (state_q == ST_DATA);
    assign idx_d       = idx_q + (IM_ADDR_W + 1)'(1);
    assign word_last   = data_fire && (lane == 2'd3) && (32'(idx_d) == 32'(len_q));
    assign len_n       = {bus.rx_data, len_lo_q};
    assign len_bad     = (len_n == '0) || ({1'b0, len_n} > CAPACITY);
    assign timed       = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                         (state_q == ST_DATA) || (state_q == ST_CSUM);
    assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign hs_done     = ack_valid_q & bus.ack_ready;

    boot_word_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (sync_fire),
        .byte_i       (bus.rx_data),
        .byte_valid_i (data_fire),
        .word_o       (word),
        .word_valid_o (word_valid),
        .lane_o       (lane)
    );

    // Decide whether this cycle closes the frame with an ACK or a NAK.
    always_comb begin
        enter_ack = 1'b0;
        enter_nak = 1'b0;
        if (timed && !rx_fire && timeout_hit) enter_nak = 1'b1;
        if ((state_q == ST_LEN1) && rx_fire && len_bad) enter_nak = 1'b1;
`ifdef BOOT_CHECKSUM_EN
        if ((state_q == ST_CSUM) && rx_fire) begin
            enter_ack = (bus.rx_data == sum_q);
            enter_nak = (bus.rx_data != sum_q);
        end
`else
        if (word_last) enter_ack = 1'b1;
`endif
    end

    // Frame FSM with registered outputs, word index, timeout and checksum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rx_ready_q   <= 1'b0;
            ack_valid_q  <= 1'b0;
            ack_data_q   <= '0;
            core_run_q   <= 1'b0;
            boot_error_q <= 1'b0;
            len_lo_q     <= '0;
            len_q        <= '0;
            idx_q        <= '0;
            addr_q       <= BASE_ADDR;
            to_cnt_q     <= '0;
`ifdef BOOT_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            if (rx_fire || !timed) to_cnt_q <= '0;
            else                   to_cnt_q <= to_cnt_q + TO_W'(1);

            if (rx_fire && (state_q == ST_LEN0)) len_lo_q <= bus.rx_data;
            if (rx_fire && (state_q == ST_LEN1)) len_q    <= len_n;

            if (sync_fire) begin
                idx_q <= '0;
            end else if (data_fire && (lane == 2'd3)) begin
                idx_q  <= idx_d;
                addr_q <= BASE_ADDR + (32'(idx_q) << 2);
            end
`ifdef BOOT_CHECKSUM_EN
            if (sync_fire)      sum_q <= '0;
            else if (data_fire) sum_q <= sum_q + bus.rx_data;
`endif

            if (enter_ack || enter_nak) begin
                state_q     <= enter_ack ? ST_ACK : ST_NAK;
                rx_ready_q  <= 1'b0;
                ack_valid_q <= 1'b1;
                ack_data_q  <= enter_ack ? BOOT_ACK : BOOT_NAK;
                if (enter_nak) boot_error_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        rx_ready_q <= 1'b1;
                        if (sync_fire) begin
                            state_q      <= ST_LEN0;
                            boot_error_q <= 1'b0;
                        end
                    end
                    ST_LEN0: if (rx_fire) state_q <= ST_LEN1;
                    ST_LEN1: if (rx_fire) state_q <= ST_DATA;
`ifdef BOOT_CHECKSUM_EN
                    ST_DATA: if (word_last) state_q <= ST_CSUM;
`endif
                    ST_ACK: if (hs_done) begin
                        state_q     <= ST_RUN;
                        ack_valid_q <= 1'b0;
                        core_run_q  <= 1'b1;
                        rx_ready_q  <= 1'b1;
                    end
                    ST_NAK: if (hs_done) begin
                        state_q     <= ST_IDLE;
                        ack_valid_q <= 1'b0;
                        rx_ready_q  <= 1'b1;
                    end
                    ST_RUN:  rx_ready_q <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign bus.rx_ready   = rx_ready_q;
    assign bus.im_wr_en   = word_valid;
    assign bus.im_wr_addr = addr_q;
    assign bus.im_wr_data = word;
    assign bus.ack_valid  = ack_valid_q;
    assign bus.ack_data   = ack_data_q;
    assign bus.core_run   = core_run_q;
    assign bus.boot_error = boot_error_q;

endmodule
